// File: rtl/load_miss_buffer_mc.sv
// Load miss buffer: holds cache-missing loads until fill data arrives, merges forwarded and
// filled bytes, extends the result and offers completed loads to CDB arbitration.
module load_miss_buffer_mc #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned NUM_MSHR    = 4,
    parameter int unsigned BLOCK_WORDS = 2,
    parameter int unsigned NUM_FILL    = 2,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned BM_W        = 4,
    localparam int unsigned MSHR_W     = $clog2(NUM_MSHR),
    localparam int unsigned WIDX_W     = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1,
    localparam int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               alloc_valid,
    input  logic [TAG_W-1:0]                   alloc_tag,
    input  logic [31:0]                        alloc_addr,
    input  logic [2:0]                         alloc_func,
    input  logic [BM_W-1:0]                    alloc_bmask,
    input  logic [MSHR_W-1:0]                  alloc_mshr,
    input  logic [3:0]                         alloc_pend,
    input  logic [31:0]                        alloc_data,
    output logic                               alloc_ready,
    input  logic [NUM_FILL-1:0]                fill_valid,
    input  logic [NUM_FILL*MSHR_W-1:0]         fill_mshr,
    input  logic [NUM_FILL*BLOCK_WORDS*32-1:0] fill_data,
    output logic [DEPTH-1:0]                   cdb_req,
    input  logic [DEPTH-1:0]                   cdb_gnt,
    output logic [DEPTH*TAG_W-1:0]             cdb_tag,
    output logic [DEPTH*32-1:0]                cdb_data,
    input  logic [BM_W-1:0]                    br_resolve,
    input  logic                               br_mispred,
    output logic [OCC_W-1:0]                   occupancy
);

    localparam int unsigned OFF_W  = 2 + WIDX_W;
    localparam int unsigned LINE_W = NUM_FILL * BLOCK_WORDS * 32;

    typedef enum logic [1:0] {StEmpty, StWait, StReady} state_e;

    state_e            r_state [DEPTH];
    state_e            w_state_nxt [DEPTH];
    logic [TAG_W-1:0]  r_tag [DEPTH];
    logic [TAG_W-1:0]  w_tag_nxt [DEPTH];
    logic [OFF_W-1:0]  r_off [DEPTH];
    logic [OFF_W-1:0]  w_off_nxt [DEPTH];
    logic [2:0]        r_func [DEPTH];
    logic [2:0]        w_func_nxt [DEPTH];
    logic [BM_W-1:0]   r_bmask [DEPTH];
    logic [BM_W-1:0]   w_bmask_nxt [DEPTH];
    logic [MSHR_W-1:0] r_mshr [DEPTH];
    logic [MSHR_W-1:0] w_mshr_nxt [DEPTH];
    logic [3:0]        r_pend [DEPTH];
    logic [3:0]        w_pend_nxt [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [31:0]       w_data_nxt [DEPTH];
    logic [OCC_W-1:0]  r_occ;
    logic [OCC_W-1:0]  w_occ_nxt;

    logic [DEPTH-1:0]  w_alloc_oh;
    logic              w_alloc_fire;
    logic              w_alloc_squash;
    logic              w_byp_hit;
    logic [31:0]       w_byp_word;
    logic [3:0]        w_alloc_pend_eff;
    logic [31:0]       w_alloc_data_eff;
    logic [DEPTH-1:0]  w_fill_hit;
    logic [31:0]       w_fill_word [DEPTH];
    logic              w_unused_addr;

    assign w_unused_addr = ^alloc_addr[31:OFF_W];

    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input int ch,
                                              input logic [OFF_W-1:0] off);
        int widx;
        widx = (BLOCK_WORDS > 1) ? int'(off[OFF_W-1:2]) : 0;
        return line[(ch * BLOCK_WORDS + widx) * 32 +: 32];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] data, input logic [3:0] pend,
                                                input logic [31:0] word);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = pend[b] ? word[8*b +: 8] : data[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] lo,
                                           input logic [2:0] func);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (func[1:0])
            2'd0:    return func[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return func[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Lowest-index EMPTY entry from registered state; entries freed this cycle are not eligible.
    always_comb begin
        w_alloc_oh  = '0;
        alloc_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!alloc_ready && r_state[i] == StEmpty) begin
                w_alloc_oh[i] = 1'b1;
                alloc_ready   = 1'b1;
            end
        end
    end

    // Descending channel scan so the lowest matching channel wins.
    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_word = '0;
        for (int c = NUM_FILL - 1; c >= 0; c--) begin
            if (fill_valid[c] && fill_mshr[c*MSHR_W +: MSHR_W] == alloc_mshr) begin
                w_byp_hit  = 1'b1;
                w_byp_word = line_word(fill_data, c, alloc_addr[OFF_W-1:0]);
            end
        end
        w_alloc_fire     = alloc_valid && alloc_ready;
        w_alloc_squash   = br_mispred && (|(alloc_bmask & br_resolve));
        w_alloc_pend_eff = w_byp_hit ? 4'b0 : alloc_pend;
        w_alloc_data_eff = w_byp_hit ? merge_bytes(alloc_data, alloc_pend, w_byp_word)
                                     : alloc_data;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_fill_hit[i]  = 1'b0;
            w_fill_word[i] = '0;
            for (int c = NUM_FILL - 1; c >= 0; c--) begin
                if (fill_valid[c] && fill_mshr[c*MSHR_W +: MSHR_W] == r_mshr[i]) begin
                    w_fill_hit[i]  = 1'b1;
                    w_fill_word[i] = line_word(fill_data, c, r_off[i]);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_tag_nxt[i]   = r_tag[i];
            w_off_nxt[i]   = r_off[i];
            w_func_nxt[i]  = r_func[i];
            w_bmask_nxt[i] = r_bmask[i];
            w_mshr_nxt[i]  = r_mshr[i];
            w_pend_nxt[i]  = r_pend[i];
            w_data_nxt[i]  = r_data[i];
            case (r_state[i])
                StWait: begin
                    if (w_fill_hit[i]) begin
                        w_data_nxt[i]  = merge_bytes(r_data[i], r_pend[i], w_fill_word[i]);
                        w_pend_nxt[i]  = 4'b0;
                        w_state_nxt[i] = StReady;
                    end
                end
                StReady: begin
                    if (cdb_gnt[i]) w_state_nxt[i] = StEmpty;
                end
                default: ;
            endcase
            // Mispredict squash overrides any same-cycle fill or grant.
            if (r_state[i] != StEmpty) begin
                if (br_mispred && (|(r_bmask[i] & br_resolve))) begin
                    w_state_nxt[i] = StEmpty;
                end else begin
                    w_bmask_nxt[i] = r_bmask[i] & ~br_resolve;
                end
            end
            if (w_alloc_fire && w_alloc_oh[i] && !w_alloc_squash) begin
                w_state_nxt[i] = (w_alloc_pend_eff == 4'b0) ? StReady : StWait;
                w_tag_nxt[i]   = alloc_tag;
                w_off_nxt[i]   = alloc_addr[OFF_W-1:0];
                w_func_nxt[i]  = alloc_func;
                w_bmask_nxt[i] = alloc_bmask & ~br_resolve;
                w_mshr_nxt[i]  = alloc_mshr;
                w_pend_nxt[i]  = w_alloc_pend_eff;
                w_data_nxt[i]  = w_alloc_data_eff;
            end
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_state_nxt[i] != StEmpty) w_occ_nxt = w_occ_nxt + OCC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= StEmpty;
                r_tag[i]   <= '0;
                r_off[i]   <= '0;
                r_func[i]  <= '0;
                r_bmask[i] <= '0;
                r_mshr[i]  <= '0;
                r_pend[i]  <= '0;
                r_data[i]  <= '0;
            end
            r_occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tag[i]   <= w_tag_nxt[i];
                r_off[i]   <= w_off_nxt[i];
                r_func[i]  <= w_func_nxt[i];
                r_bmask[i] <= w_bmask_nxt[i];
                r_mshr[i]  <= w_mshr_nxt[i];
                r_pend[i]  <= w_pend_nxt[i];
                r_data[i]  <= w_data_nxt[i];
            end
            r_occ <= w_occ_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cdb_req[i]                   = (r_state[i] == StReady);
            cdb_tag[i*TAG_W +: TAG_W]    = cdb_req[i] ? r_tag[i] : '0;
            cdb_data[i*32 +: 32]         = cdb_req[i] ? extend(r_data[i], r_off[i][1:0], r_func[i])
                                                      : '0;
        end
    end

    assign occupancy = r_occ;

endmodule
